audio_i2s_receiver: RTL and testbench

I2S receiver for the ADC side of the audio codec, the inbound counterpart of the synth engine's I2S DAC driver. It deserialises iAUD_ADCDAT, MSB first, framed by iAUD_ADCLRCK, in the iAUD_BCLK domain. It presents one signed left/right word pair per LRCK frame, with a single-cycle valid strobe, to downstream audio processing.

---
 rtl/audio_i2s_receiver.sv | 134 +++++++++++++
 tb/tb_audio_i2s_receiver.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/audio_i2s_receiver.sv
// I2S ADC receiver: deserialises iAUD_ADCDAT framed by iAUD_ADCLRCK into signed L/R word pairs.
// Define AUD_RX_LEFT_JUSTIFIED_EN for left-justified framing (MSB on the LRCK transition cycle).
module audio_i2s_receiver #(
  parameter int unsigned AUD_BIT_DEPTH = 32
) (
  input  logic                     iAUD_BCLK,
  input  logic                     reset_reg_N,
  input  logic                     iAUD_ADCLRCK,
  input  logic                     iAUD_ADCDAT,
  output logic [AUD_BIT_DEPTH-1:0] o_lsound_in,
  output logic [AUD_BIT_DEPTH-1:0] o_rsound_in,
  output logic                     o_frame_valid
);

  localparam int unsigned W  = AUD_BIT_DEPTH;
  localparam int unsigned CW = 6;
  localparam logic [CW-1:0] CNT_FULL = CW'(W);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          lrck_q, lrck_d;
  logic [W-1:0]  sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          chan_pend_q, chan_pend_d;
  logic          synced_q, synced_d;
  logic [W-1:0]  l_hold_q, l_hold_d;
  logic [W-1:0]  lsound_q, lsound_d;
  logic [W-1:0]  rsound_q, rsound_d;
  logic          valid_q, valid_d;

  logic          start_c;
  logic          commit_c;
  logic          commit_ch_c;

  assign start_c = (iAUD_ADCLRCK != lrck_q);

  always_ff @(posedge iAUD_BCLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      lrck_q      <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      chan_pend_q <= 1'b0;
      synced_q    <= 1'b0;
      l_hold_q    <= '0;
      lsound_q    <= '0;
      rsound_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      lrck_q      <= lrck_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      chan_pend_q <= chan_pend_d;
      synced_q    <= synced_d;
      l_hold_q    <= l_hold_d;
      lsound_q    <= lsound_d;
      rsound_q    <= rsound_d;
      valid_q     <= valid_d;
    end
  end

  // Word assembly, framing and channel commit.
  always_comb begin
    lrck_d      = iAUD_ADCLRCK;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    chan_pend_d = chan_pend_q;
    synced_d    = synced_q;
    l_hold_d    = l_hold_q;
    lsound_d    = lsound_q;
    rsound_d    = rsound_q;
    valid_d     = 1'b0;
    commit_c    = 1'b0;
    commit_ch_c = 1'b0;

`ifdef AUD_RX_LEFT_JUSTIFIED_EN
    if (start_c) begin
      if (synced_q) begin
        commit_c    = 1'b1;
        commit_ch_c = lrck_q;
      end else begin
        synced_d = 1'b1;
      end
      sr_d  = {iAUD_ADCDAT, {(W-1){1'b0}}};
      cnt_d = CNT_ONE;
    end else if (cnt_q < CNT_FULL) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (cnt_q == CW'(W - 1 - i)) sr_d[i] = iAUD_ADCDAT;
      end
      cnt_d = cnt_q + CNT_ONE;
    end
`else
    // Cycle after a start: the finished word is committed and the MSB is loaded.
    if (pend_q) begin
      if (synced_q) begin
        commit_c    = 1'b1;
        commit_ch_c = chan_pend_q;
      end else begin
        synced_d = 1'b1;
      end
      sr_d   = {iAUD_ADCDAT, {(W-1){1'b0}}};
      cnt_d  = CNT_ONE;
      pend_d = 1'b0;
    end else if (cnt_q < CNT_FULL) begin
      for (int unsigned i = 0; i < W; i++) begin
        if (cnt_q == CW'(W - 1 - i)) sr_d[i] = iAUD_ADCDAT;
      end
      cnt_d = cnt_q + CNT_ONE;
    end
    if (start_c) begin
      pend_d      = 1'b1;
      chan_pend_d = lrck_q;
    end
`endif

    // Left word waits in l_hold so both channels are presented together.
    if (commit_c) begin
      if (commit_ch_c) begin
        lsound_d = l_hold_q;
        rsound_d = sr_q;
        valid_d  = 1'b1;
      end else begin
        l_hold_d = sr_q;
      end
    end
  end

  assign o_lsound_in   = lsound_q;
  assign o_rsound_in   = rsound_q;
  assign o_frame_valid = valid_q;

endmodule

// File: tb/tb_audio_i2s_receiver.sv
// Scoreboard bench for audio_i2s_receiver: 32-bit and 16-bit instances share one serial stream.
module tb_audio_i2s_receiver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lrck;
  logic        dat;
  logic [31:0] l32, r32;
  logic [15:0] l16, r16;
  logic        v32, v16;

  always #5 clk = ~clk;

  audio_i2s_receiver #(.AUD_BIT_DEPTH(32)) u_d32 (
    .iAUD_BCLK(clk), .reset_reg_N(rst_n), .iAUD_ADCLRCK(lrck), .iAUD_ADCDAT(dat),
    .o_lsound_in(l32), .o_rsound_in(r32), .o_frame_valid(v32)
  );

  audio_i2s_receiver #(.AUD_BIT_DEPTH(16)) u_d16 (
    .iAUD_BCLK(clk), .reset_reg_N(rst_n), .iAUD_ADCLRCK(lrck), .iAUD_ADCDAT(dat),
    .o_lsound_in(l16), .o_rsound_in(r16), .o_frame_valid(v16)
  );

`ifdef AUD_RX_LEFT_JUSTIFIED_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    int          at;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          edge_n   = 0;
  logic        staged   = 1'b0;
  logic [31:0] st_l, st_r;
  logic        dly      = 1'b0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, req, edge_n);
    end
  endtask

  // Expected pair is queued on the LRCK 1->0 transition that commits it.
  task automatic slot(input logic lr, input logic [31:0] w, input int n);
    logic cur;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0 && lr == 1'b0 && lrck == 1'b1 && staged) begin
        q.push_back('{st_l, st_r, edge_n + LAT});
        staged = 1'b0;
      end
      lrck = lr;
      cur  = (c < 32) ? w[31-c] : 1'b0;
`ifdef AUD_RX_LEFT_JUSTIFIED_EN
      dat = cur;
`else
      dat = dly;
`endif
      dly = cur;
    end
  endtask

  task automatic stage(input logic [31:0] el, input logic [31:0] er);
    st_l   = el;
    st_r   = er;
    staged = 1'b1;
  endtask

  task automatic frame(input logic [31:0] wl, input logic [31:0] wr, input int n,
                       input logic [31:0] el, input logic [31:0] er);
    slot(1'b0, wl, n);
    stage(el, er);
    slot(1'b1, wr, n);
  endtask

  // Monitor: every presented frame must match the head of the queue, on the expected edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (v32 || v16) begin
      chk("valid16_vs_valid32", {31'h0, v16}, {31'h0, v32});
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid at edge %0d expected none", edge_n);
      end else begin
        e = q.pop_front();
        chk("left32",  l32, e.l);
        chk("right32", r32, e.r);
        chk("left16",  {16'h0, l16}, {16'h0, e.l[31:16]});
        chk("right16", {16'h0, r16}, {16'h0, e.r[31:16]});
        chk("valid_edge", 32'(edge_n), 32'(e.at));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    lrck  = 1'b0;
    dat   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_left32",  l32, 32'h0);
    chk("rst_right32", r32, 32'h0);
    chk("rst_valid",   {31'h0, v32}, 32'h0);
    chk("rst_left16",  {16'h0, l16}, 32'h0);
    chk("rst_cnt32",   {26'h0, u_d32.cnt_q}, 32'h0);
    rst_n = 1'b1;

    // Sync slot; the first presented pair has no left word behind it.
    stage(32'h0, 32'h1111_1111);
    slot(1'b1, 32'h1111_1111, 32);
    frame(32'h8000_0001, 32'h7FFF_FFFE, 32, 32'h8000_0001, 32'h7FFF_FFFE);
    frame(32'h1234_5678, 32'hDEAD_BEEF, 32, 32'h1234_5678, 32'hDEAD_BEEF);
    // 48fs: 24-bit slots, LSBs zero-filled.
    frame(32'hABCD_EF00, 32'h6543_2100, 24, 32'hABCD_EF00, 32'h6543_2100);
    frame(32'hA5A5_5A5A, 32'h0F0F_F0F0, 32, 32'hA5A5_5A5A, 32'h0F0F_F0F0);
    // LRCK toggling every cycle: one-bit words.
    frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'h8000_0000);
    frame(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'h8000_0000);

    // LRCK static low: counters saturate, outputs hold.
    slot(1'b0, 32'hCAFE_F00D, 200);
    chk("static_left32",  l32, 32'h8000_0000);
    chk("static_right32", r32, 32'h8000_0000);
    chk("static_valid",   {31'h0, v32}, 32'h0);
    chk("static_cnt32",   {26'h0, u_d32.cnt_q}, 32'd32);
    chk("static_cnt16",   {26'h0, u_d16.cnt_q}, 32'd16);
    stage(32'hCAFE_F00D, 32'h1357_9BDF);
    slot(1'b1, 32'h1357_9BDF, 32);

    // Reset in the middle of a left word.
    slot(1'b0, 32'h2468_ACE0, 16);
    rst_n = 1'b0;
    #1;
    chk("midrst_left32", l32, 32'h0);
    chk("midrst_valid",  {31'h0, v32}, 32'h0);
    slot(1'b0, 32'h0, 4);
    rst_n = 1'b1;
    slot(1'b0, 32'h0, 12);
    stage(32'h0, 32'h7654_3210);
    slot(1'b1, 32'h7654_3210, 32);
    frame(32'h1020_3040, 32'h5060_7080, 32, 32'h1020_3040, 32'h5060_7080);
    slot(1'b0, 32'h0, 32);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL missing_frames: got %0d frames outstanding expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
